// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, MEM/WB state encoding, WB bundle.
// The WB bubble constant is the all-zero bundle.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HALTED
    } mem_state_t;

    typedef struct packed {
        word_t       pc;
        word_t       instr;
        word_t       alu_out;
        word_t       imm;
        word_t       dmemload;
        logic [4:0]  wsel;
        logic        RegWr;
        logic        MemtoReg;
        logic        is_halt;
        logic [1:0]  WriteSrc;
    } wb_t;

    localparam wb_t WB_BUBBLE = '0;

endpackage

// File: rtl/mem_wb_register.sv
// MEM/WB pipeline register.
// Ports: CLK, nRST (async low), en (load), flush (load bubble, wins), d/q bundle.
module mem_wb_register
    import cpu_types_pkg::*;
(
    input  logic CLK,
    input  logic nRST,
    input  logic en,
    input  logic flush,
    input  wb_t  d,
    output wb_t  q
);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            q <= WB_BUBBLE;
        end else if (flush) begin
            q <= WB_BUBBLE;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage dcache sequencer plus MEM/WB register.
// Ports: MEM-stage operands/controls in, dcache request out,
//        mem_stall, WB register fields, sticky halt, stall cycle count.
module mem_wb_stage
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [31:0]       pc_MEM,
    input  logic [31:0]       instr_MEM,
    input  logic [31:0]       alu_out_MEM,
    input  logic [31:0]       busB_MEM,
    input  logic [31:0]       imm_MEM,
    input  logic [4:0]        wsel_MEM,
    input  logic              MemWr_MEM,
    input  logic              MemRead_MEM,
    input  logic              MemtoReg_MEM,
    input  logic              RegWr_MEM,
    input  logic              is_halt_MEM,
    input  logic              datomic_MEM,
    input  logic [1:0]        WriteSrc_MEM,
    input  logic              flush_MEM_WB,
    input  logic              dhit,
    input  logic [31:0]       dmemload,
    output logic              dREN,
    output logic              dWEN,
    output logic              datomic,
    output logic [31:0]       dmemaddr,
    output logic [31:0]       dmemstore,
    output logic              mem_stall,
    output logic [31:0]       pc_WB,
    output logic [31:0]       instr_WB,
    output logic [31:0]       alu_out_WB,
    output logic [31:0]       imm_WB,
    output logic [31:0]       dmemload_WB,
    output logic [4:0]        wsel_WB,
    output logic              RegWr_WB,
    output logic              MemtoReg_WB,
    output logic              is_halt_WB,
    output logic [1:0]        WriteSrc_WB,
    output logic              halt,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    mem_state_t       state_q;
    logic             halt_q;
    logic [CNT_W-1:0] scnt_q;

    logic mem_op;
    logic req;
    logic halted;
    logic wb_flush;
    wb_t  wb_d;
    wb_t  wb_q;

    assign mem_op = MemRead_MEM | MemWr_MEM;
    assign halted = (state_q == HALTED);

    // nRST gates the request so the dcache sees nothing during reset.
    assign req = nRST & ~halted & mem_op;

    assign dREN      = req & MemRead_MEM;
    assign dWEN      = req & MemWr_MEM;
    assign datomic   = req & datomic_MEM;
    assign dmemaddr  = req ? alu_out_MEM : '0;
    assign dmemstore = req ? busB_MEM : '0;
    assign mem_stall = req & ~dhit;

    // A stalled op must never be dropped, so stall masks flush by
    // loading a bubble itself and holding the request open.
    assign wb_flush = mem_stall | flush_MEM_WB | halted;

    always_comb begin
        wb_d          = WB_BUBBLE;
        wb_d.pc       = pc_MEM;
        wb_d.instr    = instr_MEM;
        wb_d.alu_out  = alu_out_MEM;
        wb_d.imm      = imm_MEM;
        wb_d.dmemload = dmemload;
        wb_d.wsel     = wsel_MEM;
        wb_d.RegWr    = RegWr_MEM;
        wb_d.MemtoReg = MemtoReg_MEM;
        wb_d.is_halt  = is_halt_MEM;
        wb_d.WriteSrc = WriteSrc_MEM;
    end

    mem_wb_register u_reg (
        .CLK   (CLK),
        .nRST  (nRST),
        .en    (~halted),
        .flush (wb_flush),
        .d     (wb_d),
        .q     (wb_q)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            halt_q  <= 1'b0;
            scnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_op) begin
                        if (!dhit) state_q <= WAIT;
                    end else if (is_halt_MEM && !flush_MEM_WB) begin
                        state_q <= HALTED;
                        halt_q  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (scnt_q != '1) scnt_q <= scnt_q + CNT_ONE;
                    if (dhit) state_q <= IDLE;
                end
                HALTED: begin
                    halt_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pc_WB        = wb_q.pc;
    assign instr_WB     = wb_q.instr;
    assign alu_out_WB   = wb_q.alu_out;
    assign imm_WB       = wb_q.imm;
    assign dmemload_WB  = wb_q.dmemload;
    assign wsel_WB      = wb_q.wsel;
    assign RegWr_WB     = wb_q.RegWr;
    assign MemtoReg_WB  = wb_q.MemtoReg;
    assign is_halt_WB   = wb_q.is_halt;
    assign WriteSrc_WB  = wb_q.WriteSrc;
    assign halt         = halt_q;
    assign stall_cycles = scnt_q;

endmodule
